pc_sequencer: RTL and testbench

//  Consumes addrdecision/whichtoreg from the branch-and-jump control unit; owns the PC register.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/next_pc_calc.sv | 32 +++
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: next-address select codes and FSM states.
package pc_sequencer_pkg;

  localparam logic [1:0] AD_SEQ    = 2'b00;
  localparam logic [1:0] AD_JUMP   = 2'b01;
  localparam logic [1:0] AD_BRANCH = 2'b10;
  localparam logic [1:0] AD_BREG   = 2'b11;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, jump, PC-relative branch, register target.
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  addrdecision,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_value,
  output logic [31:0] next_pc,
  output logic [31:0] p4,
  output logic        misalign_raw
);

  logic [31:0] br_off;

  assign p4           = pc + 32'd4;
  assign br_off       = {{14{imm16[15]}}, imm16, 2'b00};
  assign misalign_raw = (addrdecision == AD_BREG) && (rs_value[1:0] != 2'b00);

  always_comb begin
    next_pc = p4;
    case (addrdecision)
      AD_SEQ:    next_pc = p4;
      AD_JUMP:   next_pc = {p4[31:28], target26, 2'b00};
      AD_BRANCH: next_pc = p4 + br_off;
      AD_BREG:   next_pc = {rs_value[31:2], 2'b00};
      default:   next_pc = p4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC, runs the fetch handshake, holds the in-flight instruction and link value.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addrdecision,
  input  logic        whichtoreg,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_value,
  input  logic        instr_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] link_data,
  output logic        link_we,
  output logic        misalign
);

  state_t      state, state_next;
  logic        fetch_ok, retire;
  logic [31:0] next_pc, p4;
  logic        misalign_raw;

  next_pc_calc u_npc (
    .pc           (pc),
    .addrdecision (addrdecision),
    .imm16        (imm16),
    .target26     (target26),
    .rs_value     (rs_value),
    .next_pc      (next_pc),
    .p4           (p4),
    .misalign_raw (misalign_raw)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    fetch_ok   = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        fetch_ok = imem_ack;
        if (imem_ack) state_next = S_EXEC;
      end
      S_EXEC: begin
        retire = instr_done;
        if (instr_done) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // link_we and misalign are single-cycle pulses following the retire cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      link_data   <= 32'h0;
      link_we     <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      link_we  <= 1'b0;
      misalign <= 1'b0;
      if (fetch_ok) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
        misalign    <= misalign_raw;
        if (!whichtoreg) begin
          link_data <= p4;
          link_we   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of retire vectors plus hand sequences for stalls and reset.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addrdecision;
  logic        whichtoreg;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_value;
  logic        instr_done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] link_data;
  logic        link_we;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .addrdecision (addrdecision),
    .whichtoreg   (whichtoreg),
    .imm16        (imm16),
    .target26     (target26),
    .rs_value     (rs_value),
    .instr_done   (instr_done),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .link_data    (link_data),
    .link_we      (link_we),
    .misalign     (misalign)
  );

  typedef struct {
    logic [1:0]  dec;
    logic        wtr;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic        exp_we;
    logic [31:0] exp_link;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs a fetch from S_FETCH with the given number of wait cycles before ack.
  task automatic do_fetch(input int waits, input logic [31:0] word, input logic [31:0] exp_pc);
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      check("fetch_wait_req", {31'b0, imem_req}, 32'd1);
      check("fetch_wait_addr", imem_addr, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    check("fetch_valid", {31'b0, instr_valid}, 32'd1);
    check("fetch_instr", instr, word);
    check("fetch_req_low", {31'b0, imem_req}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{AD_BREG,   1'b1, 16'h0000, 26'h0,  32'h0000_0100, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{AD_BRANCH, 1'b1, 16'hFFFE, 26'h0,  32'h0,         32'h0000_00FC, 1'b0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{AD_BREG,   1'b1, 16'h0000, 26'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{AD_SEQ,    1'b0, 16'h0000, 26'h0,  32'h0,         32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4]  = '{AD_BREG,   1'b1, 16'h0000, 26'h0,  32'h4000_0010, 32'h4000_0010, 1'b0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{AD_JUMP,   1'b1, 16'h0000, 26'h40, 32'h0,         32'h4000_0100, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6]  = '{AD_BREG,   1'b0, 16'h0000, 26'h0,  32'h0000_0200, 32'h0000_0200, 1'b1, 32'h4000_0104, 1'b0};
    vecs[7]  = '{AD_BREG,   1'b0, 16'h0000, 26'h0,  32'h0000_1003, 32'h0000_1000, 1'b1, 32'h0000_0204, 1'b1};
    vecs[8]  = '{AD_SEQ,    1'b1, 16'h0000, 26'h0,  32'h0,         32'h0000_1004, 1'b0, 32'h0000_0204, 1'b0};
    vecs[9]  = '{AD_BRANCH, 1'b0, 16'h0010, 26'h0,  32'h0,         32'h0000_1048, 1'b1, 32'h0000_1008, 1'b0};
    vecs[10] = '{AD_BREG,   1'b1, 16'h0000, 26'h0,  32'h0000_2002, 32'h0000_2000, 1'b0, 32'h0000_1008, 1'b1};

    reset = 1'b1; addrdecision = AD_SEQ; whichtoreg = 1'b1; imm16 = '0; target26 = '0;
    rs_value = '0; instr_done = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_link", link_data, 32'h0);
    check("rst_link_we", {31'b0, link_we}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd1);

    // Reset release, ack arrives after two wait cycles: address held for three cycles
    reset = 1'b0;
    do_fetch(2, 32'hA000_0000, 32'h0);

    for (int i = 0; i < 11; i++) begin
      addrdecision = vecs[i].dec; whichtoreg = vecs[i].wtr; imm16 = vecs[i].imm;
      target26 = vecs[i].tgt; rs_value = vecs[i].rs; instr_done = 1'b1;
      @(negedge clk);
      instr_done = 1'b0;
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_link_we", i), {31'b0, link_we}, {31'b0, vecs[i].exp_we});
      check($sformatf("v%0d_link", i), link_data, vecs[i].exp_link);
      check($sformatf("v%0d_misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, 32'd0);
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_we_drop", i), {31'b0, link_we}, 32'd0);
      check($sformatf("v%0d_mis_drop", i), {31'b0, misalign}, 32'd0);
      do_fetch(i % 3, 32'hB000_0000 + i, vecs[i].exp_pc);
    end

    // Stall in S_EXEC: nothing moves while instr_done stays low
    addrdecision = AD_SEQ; whichtoreg = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_pc", pc, 32'h0000_2000);
      check("stall_instr", instr, 32'hB000_000A);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_link_we", {31'b0, link_we}, 32'd0);
    end
    whichtoreg = 1'b1; instr_done = 1'b1;
    @(negedge clk);
    check("stall_retire_pc", pc, 32'h0000_2004);

    // instr_done during S_FETCH (no ack) must not advance the PC
    whichtoreg = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("fetch_done_pc", pc, 32'h0000_2004);
      check("fetch_done_req", {31'b0, imem_req}, 32'd1);
      check("fetch_done_we", {31'b0, link_we}, 32'd0);
    end
    instr_done = 1'b0;
    do_fetch(0, 32'hC000_0001, 32'h0000_2004);

    // Reset in S_EXEC coincident with a linking retire
    whichtoreg = 1'b0; instr_done = 1'b1; reset = 1'b1;
    @(negedge clk);
    instr_done = 1'b0;
    check("rst_exec_pc", pc, 32'h0);
    check("rst_exec_we", {31'b0, link_we}, 32'd0);
    check("rst_exec_valid", {31'b0, instr_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_exec_we_after", {31'b0, link_we}, 32'd0);
    check("rst_exec_req", {31'b0, imem_req}, 32'd1);
    check("rst_exec_pc_after", pc, 32'h0);

    // Reset in S_FETCH with ack present: the ack is discarded
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("rst_fetch_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_fetch_instr", instr, 32'h0);
    check("rst_fetch_req", {31'b0, imem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
